// File: rtl/fog_rate_pkg.sv
// Shared types and constants for the FOG decimating rate accumulator.
package fog_rate_pkg;

  localparam int RATE_W = 32;
  localparam int SEQ_W  = 8;

  localparam logic [RATE_W-1:0] RATE_MAX = 32'h7FFF_FFFF;
  localparam logic [RATE_W-1:0] RATE_MIN = 32'h8000_0000;
  localparam logic [7:0]        DROP_SAT = 8'hFF;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [RATE_W-1:0] rate;
  } rate_entry_t;

endpackage

// File: rtl/fog_rate_fifo.sv
// Synchronous show-ahead FIFO of rate entries with a synchronous clear.
module fog_rate_fifo
  import fog_rate_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  rate_entry_t              i_data,
  input  logic                     i_pop,
  output rate_entry_t              o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  rate_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     level_q;
  logic            do_push, do_pop;

  assign o_full  = (level_q == (AW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_data  = mem_q[rd_q];

  // A push into a full FIFO is legal when the head leaves at the same edge.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clr) mem_q[wr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (i_clr) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/fog_rate_accum.sv
// Window-sums FOG feedback steps into a show-ahead FIFO of saturated rates.
// Define FOG_RATE_ANGLE_EN to build the wrap-around angle integrator.
module fog_rate_accum
  import fog_rate_pkg::*;
#(
  parameter int IN_W       = RATE_W,   // must match the package entry width
  parameter int ACC_W      = 48,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_step_valid,
  input  logic [IN_W-1:0]               i_step,
  input  logic [15:0]                   i_win_len,
  input  logic                          i_clr,
  output logic [IN_W-1:0]               o_rate,
  output logic [7:0]                    o_seq,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [ACC_W-1:0]              o_angle,
  output logic [7:0]                    o_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam logic [ACC_W-1:0] SAT_HI = {{(ACC_W-IN_W){1'b0}}, RATE_MAX};
  localparam logic [ACC_W-1:0] SAT_LO = {{(ACC_W-IN_W){1'b1}}, RATE_MIN};

  logic [ACC_W-1:0] sum_q, sum_d, sum_nxt, step_ext;
  logic [15:0]      cnt_q, cnt_d, len_q, len_d, len_in, len_cur;
  logic             len_ok_q, len_ok_d;
  logic [7:0]       seq_q, seq_d, drop_q, drop_d;
  logic             step_fire, win_done, pop, push, full, empty;
  logic [IN_W-1:0]  rate_sat;
  rate_entry_t      wr_entry, head;

  assign step_fire = i_step_valid & ~i_clr;
  assign step_ext  = {{(ACC_W-IN_W){i_step[IN_W-1]}}, i_step};
  assign sum_nxt   = sum_q + step_ext;
  assign len_in    = (i_win_len == 16'd0) ? 16'd1 : i_win_len;
  // Until the first step of a window the live length is used; it is latched then.
  assign len_cur   = len_ok_q ? len_q : len_in;
  assign win_done  = step_fire && (({1'b0, cnt_q} + 17'd1) == {1'b0, len_cur});

  always_comb begin
    rate_sat = sum_nxt[IN_W-1:0];
    if ($signed(sum_nxt) > $signed(SAT_HI))      rate_sat = RATE_MAX;
    else if ($signed(sum_nxt) < $signed(SAT_LO)) rate_sat = RATE_MIN;
  end

  assign wr_entry = '{seq: seq_q, rate: rate_sat};
  assign pop      = o_valid & i_ready;
  assign push     = win_done & (~full | pop);

  always_comb begin
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    len_ok_d = len_ok_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    if (i_clr) begin
      sum_d    = '0;
      cnt_d    = '0;
      len_ok_d = 1'b0;
      seq_d    = '0;
      drop_d   = '0;
    end else if (win_done) begin
      sum_d    = '0;
      cnt_d    = '0;
      len_d    = len_in;
      len_ok_d = 1'b1;
      seq_d    = seq_q + 8'd1;
      if (full && !pop && drop_q != DROP_SAT) drop_d = drop_q + 8'd1;
    end else if (step_fire) begin
      sum_d    = sum_nxt;
      cnt_d    = cnt_q + 16'd1;
      len_d    = len_cur;
      len_ok_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q    <= '0;
      cnt_q    <= '0;
      len_q    <= 16'd1;
      len_ok_q <= 1'b0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      len_ok_q <= len_ok_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

  fog_rate_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_push  (push),
    .i_data  (wr_entry),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_level)
  );

  assign o_valid    = ~empty;
  assign o_rate     = empty ? '0 : head.rate;
  assign o_seq      = empty ? '0 : head.seq;
  assign o_drop_cnt = drop_q;

`ifdef FOG_RATE_ANGLE_EN
  logic [ACC_W-1:0] angle_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       angle_q <= '0;
    else if (i_clr)     angle_q <= '0;
    else if (step_fire) angle_q <= angle_q + step_ext;
  end

  assign o_angle = angle_q;
`else
  assign o_angle = '0;
`endif

endmodule

// File: tb/tb_fog_rate_accum.sv
// Randomized bench for fog_rate_accum against a window-list reference model.
module tb_fog_rate_accum;

  localparam int IN_W  = 32;
  localparam int ACC_W = 48;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              step_valid, clr, ready;
  logic [IN_W-1:0]   step;
  logic [15:0]       win_len;
  logic [IN_W-1:0]   rate;
  logic [7:0]        seq, drop_cnt;
  logic              valid;
  logic [ACC_W-1:0]  angle;
  logic [2:0]        level;

  fog_rate_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_step_valid(step_valid), .i_step(step),
    .i_win_len(win_len), .i_clr(clr), .o_rate(rate), .o_seq(seq),
    .o_valid(valid), .i_ready(ready), .o_angle(angle), .o_drop_cnt(drop_cnt),
    .o_level(level)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [39:0]      exp_q[$];
  longint           win_steps[$];
  int               m_len;
  bit               m_len_set;
  int               m_level;
  int               m_drop;
  logic [7:0]       m_seq;
  logic [ACC_W-1:0] m_angle;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int eff_len(input logic [15:0] wl);
    return (wl == 16'd0) ? 1 : int'(wl);
  endfunction

  function automatic logic [31:0] window_rate();
    longint s = 0;
    foreach (win_steps[i]) s += win_steps[i];
    s = (s <<< 16) >>> 16;                 // internal accumulator wraps at 48 bits
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    win_steps.delete();
    m_len_set = 0;
    m_len     = 1;
    m_level   = 0;
    m_drop    = 0;
    m_seq     = 0;
    m_angle   = 0;
  endtask

  task automatic check_state();
    chk("level", 64'(level), 64'(m_level));
    chk("valid", 64'(valid), 64'(m_level != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`ifdef FOG_RATE_ANGLE_EN
    chk("angle", 64'(angle), 64'(m_angle));
`else
    chk("angle", 64'(angle), 64'd0);
`endif
  endtask

  // One clock: check state after the previous edge, then drive the next edge.
  task automatic cyc(input bit sv, input logic [31:0] st, input bit c, input bit rdy,
                     input logic [15:0] wl);
    bit pop;
    @(posedge clk); #1;
    check_state();
    step_valid = sv; step = st; clr = c; ready = rdy; win_len = wl;
    if (c) begin
      model_clear();
    end else begin
      pop = rdy && (m_level > 0);
      if (sv) begin
        if (!m_len_set) begin m_len = eff_len(wl); m_len_set = 1; end
        m_angle = m_angle + {{(ACC_W-IN_W){st[31]}}, st};
        win_steps.push_back(longint'($signed(st)));
        if (win_steps.size() == m_len) begin
          if (m_level == DEPTH && !pop) begin
            if (m_drop < 255) m_drop++;
          end else begin
            exp_q.push_back({m_seq, window_rate()});
            m_level++;
          end
          m_seq = m_seq + 8'd1;
          win_steps.delete();
          m_len = eff_len(wl);
        end
      end
      if (pop) m_level--;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, win_len);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    step_valid = 0; step = 0; clr = 0; ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst_n && valid && ready && !clr) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pop_unexpected actual=seq %0d rate %0h required=no entry", seq, rate);
      end else begin
        e = exp_q.pop_front();
        chk("rate", 64'(rate), 64'(e[31:0]));
        chk("seq", 64'(seq), 64'(e[39:32]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; step_valid = 0; step = 0; clr = 0; ready = 0; win_len = 16'd4;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 4);
    chk("reset_rate", 64'(rate), 64'd0);
    chk("reset_seq", 64'(seq), 64'd0);

    // basic window
    cyc(1, 10, 0, 0, 4); cyc(1, 20, 0, 0, 4); cyc(1, -5, 0, 0, 4); cyc(1, 7, 0, 0, 4);
    cyc(0, 0, 0, 0, 4);
    chk("basic_rate_visible", 64'(rate), 64'd32);
    cyc(0, 0, 0, 1, 4);
    idle(2, 0);

    // saturation
    cyc(1, 32'h7FFF_FFFF, 0, 1, 2); cyc(1, 32'h7FFF_FFFF, 0, 1, 2);
    cyc(1, 32'h8000_0000, 0, 1, 2); cyc(1, 32'h8000_0000, 0, 1, 2);
    idle(3, 1);

    // overflow, then the post-drop sequence gap
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, i + 1, 0, 0, 1);
    idle(1, 0);
    idle(5, 1);
    cyc(1, 100, 0, 1, 1);
    idle(3, 1);

    // full with simultaneous pop
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, i, 0, 0, 1);
    cyc(1, 9, 0, 1, 1);
    idle(1, 0);
    idle(6, 1);

    // clear priority mid-window
    cyc(1, 1, 0, 0, 3); cyc(1, 1, 0, 0, 3);
    cyc(1, 99, 1, 0, 3);
    cyc(1, 1, 0, 0, 3); cyc(1, 1, 0, 0, 3); cyc(1, 1, 0, 0, 3);
    idle(3, 1);

    // window length change mid-window, angle of 5 and -8
    cyc(0, 0, 1, 0, 4);
    cyc(1, 5, 0, 0, 4); cyc(1, -8, 0, 0, 4);
    cyc(1, 3, 0, 0, 2); cyc(1, 4, 0, 0, 2);
    cyc(1, 5, 0, 0, 2); cyc(1, 6, 0, 0, 2);
    idle(4, 1);

    // asynchronous reset mid-window
    cyc(1, 7, 0, 0, 3); cyc(1, 7, 0, 0, 3);
    do_reset();
    cyc(1, 2, 0, 0, 2); cyc(1, 3, 0, 0, 2);
    idle(3, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] st;
      st = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 2000)) - 1000);
      cyc($urandom_range(0, 2) != 0, st, $urandom_range(0, 60) == 0,
          $urandom_range(0, 2) == 0, 16'($urandom_range(0, 5)));
    end
    idle(8, 1);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fog_rate_accum.md
# fog_rate_accum

Decimating rate accumulator directly downstream of the FOG closed-loop core. Sums the signed feedback step on every loop update over a programmable window. Each window total is pushed into a small show-ahead FIFO, which the CPU-side reader drains through a valid/ready handshake. Optionally keeps a wrap-around angle integral of all accepted steps.

## Interface
Parameters:
- IN_W, 32: width of the signed step input and of o_rate.
- ACC_W, 48: internal window accumulator width, and o_angle width.
- FIFO_DEPTH, 4: number of output entries; must be a power of 2, ≥ 2.

Ports:
- i_clk  in  1  loop clock; same domain as the step generator.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_step_valid  in  1  single-cycle pulse; the step value is updated (delayed step-sync strobe).
- i_step  in  IN_W  signed feedback step, sampled when i_step_valid=1.
- i_win_len  in  16  steps per window; 0 is treated as 1.
- i_clr  in  1  synchronous clear of the accumulator, window counter, FIFO, angle and drop counter.
- o_rate  out  IN_W  signed window sum at the FIFO head, saturated.
- o_seq  out  8  window sequence number at the FIFO head; wraps 255→0.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  reader accepts the head entry when o_valid & i_ready.
- o_angle  out  ACC_W  signed running integral of accepted steps, wrap-around.
- o_drop_cnt  out  8  windows lost to FIFO full; saturates at 255.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- The only state is an accumulating window counter; there are no further FSM states. The counter and the sum advance on each i_step_valid.
- Window length is latched from i_win_len when a window starts (reset, clear, or after each completion). Changes mid-window take effect at the next window.
- Normal step: sum += sign-extended i_step (ACC_W, wraps internally); cnt += 1.
- Window completion: the step for which cnt+1 == latched length.
  - The write value is sum + i_step, saturated to IN_W signed (max 0x7FFF_FFFF, min 0x8000_0000), paired with the seq counter.
  - sum and cnt restart at 0, seq += 1, the new length is latched.
- FIFO write when full and no pop in the same cycle:
  - The entry is dropped and o_drop_cnt increments.
  - seq still increments, so the gap is visible to the reader.
- Full with a simultaneous pop: the write succeeds and the level is unchanged.
- Empty with a write only: the level goes to 1. Pop on empty is impossible because o_valid=0.
- o_angle += sign-extended i_step on every i_step_valid, wrap-around, independent of FIFO state.
- i_clr has priority over i_step_valid in the same cycle. That step is discarded: no sum, angle or window contribution.
- i_win_len=0 behaves as 1, so every step produces one entry.

## Timing
- Reset and clear values: o_rate=0, o_seq=0, o_valid=0, o_angle=0, o_drop_cnt=0, o_level=0, sum=0, cnt=0, seq=0.
- Latency: completing step sampled at edge E → entry written at E → o_valid=1 with o_rate/o_seq valid after E (next cycle visible). That is 1-cycle latency when the FIFO was empty.
- Show-ahead FIFO: head data is stable while o_valid & !i_ready. A pop at edge P exposes the next entry after P.
- o_angle is updated at the same edge as the step is sampled.
- Reset asserted mid-window asynchronously clears all state, including unread FIFO entries. The first window after release starts from cnt=0.
- Back-to-back i_step_valid on consecutive cycles must be supported.

## Configuration
- FOG_RATE_ANGLE_EN defined: the angle integrator is built and o_angle behaves as above.
- Not defined: the integrator is removed and o_angle is tied to 0. All other behaviour is identical.

## Structure
- Shared package fog_rate_pkg holds:
  - typedef rate_entry_t {seq[7:0], rate[IN_W-1:0]}
  - localparams for saturation limits
  - the drop-counter saturation constant 8'hFF
- One sub-module, fog_rate_fifo: synchronous show-ahead FIFO of rate_entry_t with push/pop/full/empty/level and a sync clear.

## Test plan
- Basic window: win_len=4, steps 10, 20, -5, 7 → one entry rate=32, seq=0; o_valid rises one cycle after the 4th step; i_ready=1 pops it and o_level returns to 0.
- Saturation: win_len=2, steps 0x7FFF_FFFF, 0x7FFF_FFFF → rate=0x7FFF_FFFF; steps 0x8000_0000 twice → rate=0x8000_0000.
- Overflow: FIFO_DEPTH=4, win_len=1, i_ready=0, 6 steps → o_level=4, o_drop_cnt=2; draining gives seq 0,1,2,3; the next window's seq is 6.
- Full with simultaneous pop: FIFO full, i_ready=1 on the completing edge → o_drop_cnt unchanged, o_level stays 4.
- Clear priority: i_clr and i_step_valid in the same cycle mid-window → sum, cnt, FIFO and angle are 0; a following win_len=3 run of steps 1,1,1 gives rate=3, seq=0.
- Window length change and angle: win_len changed 4→2 after the 2nd step of a window → that window still closes at 4 steps and the next at 2. With FOG_RATE_ANGLE_EN, steps 5, -8 give o_angle = -3 (sign-extended to 48 bits); without the macro o_angle=0.
